// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle layout, bubble encoding and
// default datapath widths used by the ID/EX stage and its helpers.
package pipeline_pkg;

    localparam int CTRL_W    = 9;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Decoder bundle layout, MSB first: RegDst, AluOp[1:0], ALUSrc, Branch,
    // MemRead, MemWrite, RegWrite, MemtoReg.
    localparam int CTRL_REG_DST   = 8;
    localparam int CTRL_ALU_OP_HI = 7;
    localparam int CTRL_ALU_OP_LO = 6;
    localparam int CTRL_ALU_SRC   = 5;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_MEM_READ  = 3;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_REG_WRITE = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'h000;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Destination register select: rd for R-type, rt otherwise.
    function automatic logic [REG_W_DEF-1:0] sel_wreg(
        input ctrl_t               ctrl,
        input logic [REG_W_DEF-1:0] rt,
        input logic [REG_W_DEF-1:0] rd
    );
        return ctrl[CTRL_REG_DST] ? rd : rt;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction currently in ID.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic             id_alu_src,
    input  logic             id_mem_write,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    assign ex_is_load = ex_valid & ex_mem_read & (ex_rt != '0);
    assign rs_match   = (ex_rt == id_rs);
    // rt is only a true source when it feeds the ALU or supplies store data.
    assign rt_match   = (ex_rt == id_rt) & (~id_alu_src | id_mem_write);
    assign load_use   = ex_is_load & id_valid & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and stall.
// Optional stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  ex_wreg,
    output logic              hazard_stall,
    output logic              id_hold
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    logic load_use;
    logic load_en;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl[CTRL_MEM_READ]),
        .ex_rt        (ex_rt),
        .id_valid     (id_valid),
        .id_alu_src   (id_ctrl[CTRL_ALU_SRC]),
        .id_mem_write (id_ctrl[CTRL_MEM_WRITE]),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .load_use     (load_use)
    );

    // Flush and downstream stall both outrank the hazard, so it is masked here.
    assign hazard_stall = load_use & ~flush & ~ex_stall;
    assign id_hold      = hazard_stall | ex_stall;
    assign load_en      = ~flush & ~ex_stall & ~load_use;

    // Valid/control: a bubble is always an all-zero control word.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
        end else if (!ex_stall) begin
            if (hazard_stall) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_BUBBLE;
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_valid ? id_ctrl : CTRL_BUBBLE;
            end
        end
    end

    // Datapath: contents of a bubble are don't-care, so it simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rd1  <= '0;
            ex_rd2  <= '0;
            ex_imm  <= '0;
            ex_pc4  <= '0;
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_rd   <= '0;
            ex_wreg <= '0;
        end else if (load_en) begin
            ex_rd1  <= id_rd1;
            ex_rd2  <= id_rd2;
            ex_imm  <= id_imm;
            ex_pc4  <= id_pc4;
            ex_rs   <= id_rs;
            ex_rt   <= id_rt;
            ex_rd   <= id_rd;
            ex_wreg <= id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 16'h0000;
        end else if (hazard_stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven load/hazard vectors plus
// directed reset, flush/stall and (with ID_EX_STALL_CNT_EN) counter sequences.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [8:0] C_ADD  = 9'h182;
    localparam logic [8:0] C_LW   = 9'h02B;
    localparam logic [8:0] C_SW   = 9'h024;
    localparam logic [8:0] C_ADDI = 9'h022;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [8:0]        id_ctrl;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic              flush, ex_stall;
    logic              ex_valid;
    logic [8:0]        ex_ctrl;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd, ex_wreg;
    logic              hazard_stall, id_hold;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0]       stall_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_rd1       (id_rd1),
        .id_rd2       (id_rd2),
        .id_imm       (id_imm),
        .id_pc4       (id_pc4),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_rd1       (ex_rd1),
        .ex_rd2       (ex_rd2),
        .ex_imm       (ex_imm),
        .ex_pc4       (ex_pc4),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .ex_wreg      (ex_wreg),
        .hazard_stall (hazard_stall),
        .id_hold      (id_hold)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    typedef struct {
        logic        valid;
        logic [8:0]  ctrl;
        logic [31:0] rd1;
        logic [4:0]  rs, rt, rd;
        logic        flush, stall;
        logic        exp_hz, exp_hold, exp_valid;
        logic [8:0]  exp_ctrl;
        logic [4:0]  exp_wreg;
        logic        chk_data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive ID inputs at the falling edge; derived operands keep the table compact.
    task automatic drive(input logic v, input logic [8:0] c, input logic [31:0] r1,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic fl, input logic st);
        @(negedge clk);
        id_valid = v;
        id_ctrl  = c;
        id_rd1   = r1;
        id_rd2   = r1 + 32'd1;
        id_imm   = r1 + 32'd2;
        id_pc4   = r1 + 32'd4;
        id_rs    = s;
        id_rt    = t;
        id_rd    = d;
        flush    = fl;
        ex_stall = st;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_data(input string tag, input logic [31:0] r1,
                              input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        check({tag, ".rd1"}, ex_rd1, r1);
        check({tag, ".rd2"}, ex_rd2, r1 + 32'd1);
        check({tag, ".imm"}, ex_imm, r1 + 32'd2);
        check({tag, ".pc4"}, ex_pc4, r1 + 32'd4);
        check({tag, ".rs"},  32'(ex_rs), 32'(s));
        check({tag, ".rt"},  32'(ex_rt), 32'(t));
        check({tag, ".rd"},  32'(ex_rd), 32'(d));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        valid ctrl    rd1     rs    rt    rd    fl    st    hz    hold  vld   ectrl   wreg  data
        vecs[0]  = '{1'b1, C_ADD,  32'h11, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  5'd3, 1'b1};
        vecs[1]  = '{1'b1, C_LW,   32'h22, 5'd4, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_LW,   5'd8, 1'b1};
        vecs[2]  = '{1'b1, C_ADD,  32'h33, 5'd8, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 5'd0, 1'b0};
        vecs[3]  = '{1'b1, C_ADD,  32'h33, 5'd8, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  5'd9, 1'b1};
        vecs[4]  = '{1'b1, C_LW,   32'h44, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_LW,   5'd7, 1'b1};
        vecs[5]  = '{1'b1, C_ADDI, 32'h55, 5'd3, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADDI, 5'd7, 1'b1};
        vecs[6]  = '{1'b1, C_LW,   32'h66, 5'd2, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_LW,   5'd6, 1'b1};
        vecs[7]  = '{1'b1, C_SW,   32'h77, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 5'd0, 1'b0};
        vecs[8]  = '{1'b1, C_SW,   32'h77, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_SW,   5'd6, 1'b1};
        vecs[9]  = '{1'b0, C_ADD,  32'h88, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd3, 1'b1};
        vecs[10] = '{1'b1, C_LW,   32'h99, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_LW,   5'd0, 1'b1};
        vecs[11] = '{1'b1, C_ADD,  32'hAA, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  5'd4, 1'b1};
        vecs[12] = '{1'b1, C_ADD,  32'hBB, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 5'd0, 1'b0};
        vecs[13] = '{1'b1, C_ADD,  32'hCC, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 5'd0, 1'b0};

        // Load something non-zero, then reset with a valid add presented.
        rst = 1'b0;
        drive(1'b1, C_ADD, 32'h1234, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, C_ADD, 32'h5678, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0);
        tick();
        check("rst.valid", 32'(ex_valid), 32'd0);
        check("rst.ctrl",  32'(ex_ctrl),  32'h000);
        check("rst.rd1",   ex_rd1, 32'd0);
        check("rst.rd2",   ex_rd2, 32'd0);
        check("rst.imm",   ex_imm, 32'd0);
        check("rst.pc4",   ex_pc4, 32'd0);
        check("rst.regs",  32'({ex_rs, ex_rt, ex_rd, ex_wreg}), 32'd0);
        check("rst.hz",    32'(hazard_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].valid, vecs[i].ctrl, vecs[i].rd1, vecs[i].rs, vecs[i].rt,
                  vecs[i].rd, vecs[i].flush, vecs[i].stall);
            check({tag, ".hz"},   32'(hazard_stall), 32'(vecs[i].exp_hz));
            check({tag, ".hold"}, 32'(id_hold),      32'(vecs[i].exp_hold));
            tick();
            check({tag, ".valid"}, 32'(ex_valid), 32'(vecs[i].exp_valid));
            check({tag, ".ctrl"},  32'(ex_ctrl),  32'(vecs[i].exp_ctrl));
            if (vecs[i].chk_data) begin
                check({tag, ".wreg"}, 32'(ex_wreg), 32'(vecs[i].exp_wreg));
                check_data(tag, vecs[i].rd1, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            end
        end

        // Load-use stall: exactly one bubble, then add enters EX with wreg=rd.
        drive(1'b1, C_LW, 32'h100, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, C_ADD, 32'h200, 5'd8, 5'd2, 5'd10, 1'b0, 1'b0);
        check("lu.hz",   32'(hazard_stall), 32'd1);
        check("lu.hold", 32'(id_hold),      32'd1);
        tick();
        check("lu.bubble_valid", 32'(ex_valid), 32'd0);
        check("lu.bubble_ctrl",  32'(ex_ctrl),  32'h000);
        check("lu.hz_after",     32'(hazard_stall), 32'd0);
        tick();
        check("lu.add_valid", 32'(ex_valid), 32'd1);
        check("lu.add_ctrl",  32'(ex_ctrl),  32'(C_ADD));
        check("lu.add_wreg",  32'(ex_wreg),  32'd10);

        // Hazard coinciding with flush and ex_stall: flush wins, no hazard stall.
        drive(1'b1, C_LW, 32'h300, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, C_ADD, 32'h400, 5'd8, 5'd2, 5'd3, 1'b1, 1'b1);
        check("fs.hz",   32'(hazard_stall), 32'd0);
        check("fs.hold", 32'(id_hold),      32'd1);
        tick();
        check("fs.valid", 32'(ex_valid), 32'd0);
        check("fs.ctrl",  32'(ex_ctrl),  32'h000);

        // Three cycles of downstream stall while ID keeps changing.
        drive(1'b1, C_ADD, 32'h500, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, (k == 1) ? C_LW : C_SW, 32'h600 + 32'(k), 5'(k + 4), 5'(k + 9), 5'(k + 20), 1'b0, 1'b1);
            check($sformatf("st%0d.hold", k), 32'(id_hold), 32'd1);
            tick();
            check($sformatf("st%0d.valid", k), 32'(ex_valid), 32'd1);
            check($sformatf("st%0d.ctrl", k),  32'(ex_ctrl),  32'(C_ADD));
            check($sformatf("st%0d.wreg", k),  32'(ex_wreg),  32'd3);
            check_data($sformatf("st%0d", k), 32'h500, 5'd1, 5'd2, 5'd3);
        end

        // Reset during a load-use stall: held add is discarded, no leftover bubble.
        drive(1'b1, C_LW, 32'h700, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, C_ADD, 32'h800, 5'd8, 5'd2, 5'd3, 1'b0, 1'b0);
        check("rs.hz_before", 32'(hazard_stall), 32'd1);
        rst = 1'b1;
        tick();
        check("rs.valid", 32'(ex_valid), 32'd0);
        check("rs.ctrl",  32'(ex_ctrl),  32'h000);
        check("rs.rd1",   ex_rd1, 32'd0);
        check("rs.hz",    32'(hazard_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rs.add_valid", 32'(ex_valid), 32'd1);
        check("rs.add_ctrl",  32'(ex_ctrl),  32'(C_ADD));

`ifdef ID_EX_STALL_CNT_EN
        begin
            int hz_seen;
            hz_seen = 0;
            check("cnt.after_rst", 32'(stall_count), 32'd0);
            // lw r8,(r8) repeated: each pass alternates load and load-use bubble.
            drive(1'b1, C_LW, 32'h900, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
            for (int n = 0; n < 140000 && hz_seen < 65540; n++) begin
                if (hazard_stall) hz_seen++;
                tick();
            end
            check("cnt.hazards", 32'(hz_seen), 32'd65540);
            check("cnt.sat", 32'(stall_count), 32'hFFFF);
            @(negedge clk);
            rst = 1'b1;
            tick();
            check("cnt.cleared", 32'(stall_count), 32'd0);
            @(negedge clk);
            rst = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, shall set the operand, immediate and PC+4 width.
REQ-002 Parameter REG_W, default 5, shall set the register-index width.
REQ-003 clk  in  1  single clock; all state shall update on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID-stage instruction valid.
REQ-006 id_ctrl  in  9  decoder bundle {RegDst, AluOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}, bit 8 down to bit 0.
REQ-007 id_rd1, id_rd2  in  DATA_W  register-file read data.
REQ-008 id_imm  in  DATA_W  sign-extended immediate.
REQ-009 id_pc4  in  DATA_W  PC+4 of the ID instruction.
REQ-010 id_rs, id_rt, id_rd  in  REG_W  source and destination indices.
REQ-011 flush  in  1  branch-taken squash from EX/MEM.
REQ-012 ex_stall  in  1  downstream hold request.
REQ-013 ex_valid  out 1; ex_ctrl out 9; ex_rd1, ex_rd2, ex_imm, ex_pc4 out DATA_W; ex_rs, ex_rt, ex_rd out REG_W: registered copies of the ID inputs.
REQ-014 ex_wreg  out  REG_W  registered destination index: id_rd when RegDst=1, else id_rt.
REQ-015 hazard_stall  out  1  combinational load-use stall indication.
REQ-016 id_hold  out  1  equals hazard_stall OR ex_stall; holds PC and IF/ID.

Function
REQ-017 The load-use hazard shall be detected when ex_valid=1, ex_ctrl.MemRead=1, ex_rt!=0, id_valid=1, and either ex_rt==id_rs or (ex_rt==id_rt and (id_ctrl.ALUSrc=0 or id_ctrl.MemWrite=1)).
REQ-018 hazard_stall shall be the hazard condition ANDed with NOT flush and NOT ex_stall.
REQ-019 Update priority per cycle shall be: rst > flush > ex_stall > hazard_stall > normal load.
REQ-020 On flush, the next cycle shall have ex_valid=0 and ex_ctrl=9'h000; data registers are don't-care.
REQ-021 With ex_stall=1 (no rst or flush), every output register shall hold its value.
REQ-022 With hazard_stall=1, a bubble shall be inserted: ex_valid=0 and ex_ctrl=9'h000 next cycle; the ID instruction shall re-present one cycle later.
REQ-023 On normal load, all ex_* registers shall capture the ID inputs with 1-cycle latency; if id_valid=0, ex_ctrl shall load 9'h000.
REQ-024 ex_ctrl shall be 9'h000 whenever ex_valid=0, so that RegWrite, MemWrite, MemRead and Branch are never active in a bubble.
REQ-025 A hazard shall stall for exactly one cycle; the bubble it creates clears the MemRead condition.

Reset
REQ-026 While rst=1, all ex_* outputs shall be 0 on the next edge, and hazard_stall shall be 0 in the following cycle.
REQ-027 Reset asserted mid-stall shall discard the held instruction with no residual bubble.

Configuration
REQ-028 When ID_EX_STALL_CNT_EN is defined, the block shall add output stall_count (16 bits), incremented each cycle hazard_stall=1, saturating at 16'hFFFF, and cleared by rst.
REQ-029 When ID_EX_STALL_CNT_EN is undefined, the stall_count port and its logic shall be absent, and all other behaviour is unchanged.

Structure
REQ-030 Shared package pipeline_pkg shall hold the control-bundle width (9), the bit-index constants for each control field, CTRL_BUBBLE=9'h000, and the DATA_W and REG_W defaults.
REQ-031 The load-use comparison shall be implemented in sub-module hazard_detect (purely combinational), instantiated once.

Verification
REQ-032 rst=1 with id_valid=1 and id_ctrl=9'h182 -> next cycle ex_valid=0, ex_ctrl=9'h000, and all data 0.
REQ-033 EX holds lw (ex_ctrl=9'h02B, ex_rt=8), ID holds add (rs=8, ALUSrc=0) -> hazard_stall=1 and id_hold=1; next cycle ex_valid=0 and ex_ctrl=0; the cycle after, add is in EX with ex_wreg=id_rd.
REQ-034 lw with ex_rt=0 and ID rs=0 -> hazard_stall=0, and add loads directly.
REQ-035 Hazard plus flush=1 plus ex_stall=1 in the same cycle -> hazard_stall=0 and ex_valid=0 next cycle.
REQ-036 ex_stall=1 for 3 cycles with ID inputs changing -> ex_* outputs unchanged and id_hold=1 for all 3 cycles.
REQ-037 With ID_EX_STALL_CNT_EN defined, 65540 forced hazard cycles -> stall_count=16'hFFFF, and rst then returns it to 0.
